polygon_test_scheduler: RTL and testbench

POLYGON_TEST_SCHEDULER -- requirements
Module: polygon_test_scheduler

---
 rtl/polygon_test_scheduler.sv | 197 +++++++++++++++++++
 tb/tb_polygon_test_scheduler.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/polygon_test_scheduler.sv
// Shared point-in-polygon tester: vertex table, round-robin request arbiter,
// one combinational winding test per request and a valid/ready response port.
module polygon_test_scheduler #(
    parameter int PIXEL_WIDTH      = 1280,
    parameter int PIXEL_HEIGHT     = 720,
    parameter int MAX_NUM_VERTICES = 4,
    parameter int NUM_POLYGONS     = 4,
    parameter int NUM_REQ          = 2,
    localparam int HW  = $clog2(PIXEL_WIDTH),
    localparam int CVW = $clog2(PIXEL_HEIGHT),
    localparam int VW  = (MAX_NUM_VERTICES > 1) ? $clog2(MAX_NUM_VERTICES) : 1,
    localparam int PW  = (NUM_POLYGONS > 1) ? $clog2(NUM_POLYGONS) : 1,
    localparam int RW  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          wr_valid_in,
    input  logic [PW-1:0]                 wr_poly_in,
    input  logic [VW-1:0]                 wr_vertex_in,
    input  logic signed [31:0]            wr_x_in,
    input  logic signed [31:0]            wr_y_in,
    input  logic [NUM_REQ-1:0]            req_valid_in,
    output logic [NUM_REQ-1:0]            req_ready_out,
    input  logic [NUM_REQ-1:0][HW-1:0]    req_hcount_in,
    input  logic [NUM_REQ-1:0][CVW-1:0]   req_vcount_in,
    input  logic [NUM_REQ-1:0][PW-1:0]    req_poly_in,
    output logic                          resp_valid_out,
    input  logic                          resp_ready_in,
    output logic [RW-1:0]                 resp_id_out,
    output logic                          resp_inside_out,
    output logic                          resp_err_out,
    output logic [15:0]                   tests_done_out
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_TEST = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]          state_q, state_d;
    logic [RW-1:0]       rr_q, rr_d;
    logic [HW-1:0]       pt_h_q, pt_h_d;
    logic [CVW-1:0]      pt_v_q, pt_v_d;
    logic [PW-1:0]       slot_q, slot_d;
    logic [RW-1:0]       id_q, id_d;
    logic                inside_q, inside_d;
    logic                err_q, err_d;
    logic [15:0]         done_q, done_d;
    logic signed [31:0]  vx_q [NUM_POLYGONS][MAX_NUM_VERTICES];
    logic signed [31:0]  vx_d [NUM_POLYGONS][MAX_NUM_VERTICES];
    logic signed [31:0]  vy_q [NUM_POLYGONS][MAX_NUM_VERTICES];
    logic signed [31:0]  vy_d [NUM_POLYGONS][MAX_NUM_VERTICES];
    logic [MAX_NUM_VERTICES-1:0] mask_q [NUM_POLYGONS];
    logic [MAX_NUM_VERTICES-1:0] mask_d [NUM_POLYGONS];

    logic                grant_any;
    logic [RW-1:0]       grant_idx;
    logic                slot_ok;
    logic [PW-1:0]       tst_slot;
    logic signed [31:0]  px, py;
    logic [VW:0]         up_cnt, dn_cnt;
    logic                wind_inside;

    // Round-robin search starting at the pointer.
    always_comb begin
        int unsigned idx;
        idx       = 0;
        grant_any = 1'b0;
        grant_idx = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = (32'(rr_q) + k) % NUM_REQ;
            if (!grant_any && req_valid_in[idx]) begin
                grant_any = 1'b1;
                grant_idx = RW'(idx);
            end
        end
    end

    assign req_ready_out  = (state_q == ST_IDLE && grant_any) ? (NUM_REQ'(1) << grant_idx) : '0;
    assign resp_valid_out = (state_q == ST_RESP);
    assign resp_id_out    = id_q;
    assign resp_inside_out = inside_q;
    assign resp_err_out   = err_q;
    assign tests_done_out = done_q;

    assign slot_ok  = (32'(slot_q) < NUM_POLYGONS);
    assign tst_slot = slot_ok ? slot_q : '0;
    assign px       = $signed(32'(pt_h_q));
    assign py       = $signed(32'(pt_v_q));

    // Winding number by signed edge crossings; a nonzero count is the same
    // as the wrapped angle deltas summing to a full turn (|sum| >= 180).
    always_comb begin
        logic signed [31:0] rxa, rya, rxb, ryb;
        logic signed [63:0] ax, ay, bx, by, cr;
        int unsigned j;
        up_cnt = '0;
        dn_cnt = '0;
        rxa = '0; rya = '0; rxb = '0; ryb = '0;
        ax = '0; ay = '0; bx = '0; by = '0; cr = '0;
        j = 0;
        for (int unsigned i = 0; i < MAX_NUM_VERTICES; i++) begin
            j   = (i + 1) % MAX_NUM_VERTICES;
            rxa = vx_q[tst_slot][i] - px;
            rya = vy_q[tst_slot][i] - py;
            rxb = vx_q[tst_slot][j] - px;
            ryb = vy_q[tst_slot][j] - py;
            ax  = {{32{rxa[31]}}, rxa};
            ay  = {{32{rya[31]}}, rya};
            bx  = {{32{rxb[31]}}, rxb};
            by  = {{32{ryb[31]}}, ryb};
            cr  = ax * by - bx * ay;
            if (rya <= 0) begin
                if (ryb > 0 && cr > 64'sd0) up_cnt = up_cnt + (VW+1)'(1);
            end else begin
                if (ryb <= 0 && cr < 64'sd0) dn_cnt = dn_cnt + (VW+1)'(1);
            end
        end
        wind_inside = (up_cnt != dn_cnt);
    end

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        pt_h_d   = pt_h_q;
        pt_v_d   = pt_v_q;
        slot_d   = slot_q;
        id_d     = id_q;
        inside_d = inside_q;
        err_d    = err_q;
        done_d   = done_q;
        vx_d     = vx_q;
        vy_d     = vy_q;
        mask_d   = mask_q;

        if (wr_valid_in && 32'(wr_poly_in) < NUM_POLYGONS && 32'(wr_vertex_in) < MAX_NUM_VERTICES) begin
            vx_d[wr_poly_in][wr_vertex_in]   = wr_x_in;
            vy_d[wr_poly_in][wr_vertex_in]   = wr_y_in;
            mask_d[wr_poly_in][wr_vertex_in] = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (grant_any) begin
                    pt_h_d  = req_hcount_in[grant_idx];
                    pt_v_d  = req_vcount_in[grant_idx];
                    slot_d  = req_poly_in[grant_idx];
                    id_d    = grant_idx;
                    rr_d    = RW'((32'(grant_idx) + 1) % NUM_REQ);
                    state_d = ST_TEST;
                end
            end
            ST_TEST: begin
                err_d    = !(slot_ok && mask_q[tst_slot] == '1);
                inside_d = slot_ok && (mask_q[tst_slot] == '1) && wind_inside;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready_in) begin
                    if (done_q != 16'hFFFF) done_d = done_q + 16'd1;
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state_q  <= ST_IDLE;
            rr_q     <= '0;
            pt_h_q   <= '0;
            pt_v_q   <= '0;
            slot_q   <= '0;
            id_q     <= '0;
            inside_q <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= '0;
            vx_q     <= '{default: '0};
            vy_q     <= '{default: '0};
            mask_q   <= '{default: '0};
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            pt_h_q   <= pt_h_d;
            pt_v_q   <= pt_v_d;
            slot_q   <= slot_d;
            id_q     <= id_d;
            inside_q <= inside_d;
            err_q    <= err_d;
            done_q   <= done_d;
            vx_q     <= vx_d;
            vy_q     <= vy_d;
            mask_q   <= mask_d;
        end
    end

endmodule

// File: tb/tb_polygon_test_scheduler.sv
// Directed bench for polygon_test_scheduler: square slot, partial slot,
// round-robin order, response backpressure and reset mid-test.
module tb_polygon_test_scheduler;

    localparam int HW  = 11;
    localparam int CVW = 10;
    localparam int PW  = 2;
    localparam int VW  = 2;
    localparam int RW  = 1;
    localparam int NR  = 2;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     wr_valid;
    logic [PW-1:0]            wr_poly;
    logic [VW-1:0]            wr_vertex;
    logic signed [31:0]       wr_x, wr_y;
    logic [NR-1:0]            req_valid;
    logic [NR-1:0]            req_ready;
    logic [NR-1:0][HW-1:0]    req_hcount;
    logic [NR-1:0][CVW-1:0]   req_vcount;
    logic [NR-1:0][PW-1:0]    req_poly;
    logic                     resp_valid;
    logic                     resp_ready;
    logic [RW-1:0]            resp_id;
    logic                     resp_inside;
    logic                     resp_err;
    logic [15:0]              tests_done;

    int errors = 0;
    int checks = 0;

    polygon_test_scheduler #(
        .PIXEL_WIDTH(1280),
        .PIXEL_HEIGHT(720),
        .MAX_NUM_VERTICES(4),
        .NUM_POLYGONS(4),
        .NUM_REQ(2)
    ) dut (
        .clk_in(clk),
        .rst_in(rst),
        .wr_valid_in(wr_valid),
        .wr_poly_in(wr_poly),
        .wr_vertex_in(wr_vertex),
        .wr_x_in(wr_x),
        .wr_y_in(wr_y),
        .req_valid_in(req_valid),
        .req_ready_out(req_ready),
        .req_hcount_in(req_hcount),
        .req_vcount_in(req_vcount),
        .req_poly_in(req_poly),
        .resp_valid_out(resp_valid),
        .resp_ready_in(resp_ready),
        .resp_id_out(resp_id),
        .resp_inside_out(resp_inside),
        .resp_err_out(resp_err),
        .tests_done_out(tests_done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic wr_vtx(input int poly, input int v, input int x, input int y);
        wr_valid  = 1'b1;
        wr_poly   = PW'(poly);
        wr_vertex = VW'(v);
        wr_x      = x;
        wr_y      = y;
        tick();
        wr_valid  = 1'b0;
    endtask

    task automatic load_square;
        wr_vtx(0, 0, 100, 100);
        wr_vtx(0, 1, 200, 100);
        wr_vtx(0, 2, 200, 200);
        wr_vtx(0, 3, 100, 200);
    endtask

    // Single request from one requester, response taken on its first RESP cycle.
    task automatic do_req(input int id, input int h, input int v, input int poly,
                          input int exp_in, input int exp_err);
        req_hcount[id] = HW'(h);
        req_vcount[id] = CVW'(v);
        req_poly[id]   = PW'(poly);
        req_valid      = NR'(1) << id;
        #1;
        check("grant", 32'(req_ready), 32'(NR'(1) << id));
        tick();
        req_valid = '0;
        check("test_no_valid", 32'(resp_valid), 0);
        tick();
        check("resp_valid", 32'(resp_valid), 1);
        check("resp_id", 32'(resp_id), 32'(id));
        check("resp_inside", 32'(resp_inside), 32'(exp_in));
        check("resp_err", 32'(resp_err), 32'(exp_err));
        resp_ready = 1'b1;
        tick();
        resp_ready = 1'b0;
        check("idle_after", 32'(resp_valid), 0);
    endtask

    initial begin
        rst = 1'b1; wr_valid = 1'b0; wr_poly = '0; wr_vertex = '0; wr_x = 0; wr_y = 0;
        req_valid = '0; req_hcount = '0; req_vcount = '0; req_poly = '0; resp_ready = 1'b0;
        tick(); tick();
        rst = 1'b0;
        #1;
        check("rst_valid", 32'(resp_valid), 0);
        check("rst_done", 32'(tests_done), 0);
        check("rst_inside", 32'(resp_inside), 0);
        check("rst_err", 32'(resp_err), 0);
        check("rst_id", 32'(resp_id), 0);
        check("rst_ready", 32'(req_ready), 0);

        load_square();
        wr_vtx(1, 0, 100, 100);
        wr_vtx(1, 1, 200, 100);
        wr_vtx(1, 2, 200, 200);

        do_req(0, 150, 150, 0, 1, 0);
        do_req(0, 50, 150, 0, 0, 0);
        do_req(1, 150, 150, 1, 0, 1);
        check("done_3", 32'(tests_done), 3);

        // Both requesters held valid: pointer is back at 0, so 0,1,0,1.
        req_hcount[0] = HW'(150); req_vcount[0] = CVW'(150); req_poly[0] = '0;
        req_hcount[1] = HW'(50);  req_vcount[1] = CVW'(150); req_poly[1] = '0;
        req_valid  = 2'b11;
        resp_ready = 1'b1;
        for (int n = 0; n < 4; n++) begin
            #1;
            check("rr_grant", 32'(req_ready), (n % 2 == 0) ? 1 : 2);
            tick();
            check("rr_test_ready", 32'(req_ready), 0);
            tick();
            check("rr_valid", 32'(resp_valid), 1);
            check("rr_id", 32'(resp_id), 32'(n % 2));
            check("rr_inside", 32'(resp_inside), (n % 2 == 0) ? 1 : 0);
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b0;
        check("done_7", 32'(tests_done), 7);

        // Backpressure: five RESP cycles without ready, accepted on the sixth.
        req_hcount[0] = HW'(150); req_vcount[0] = CVW'(150); req_poly[0] = '0;
        req_valid = 2'b01;
        #1;
        check("bp_grant", 32'(req_ready), 1);
        tick();
        check("bp_test_ready", 32'(req_ready), 0);
        tick();
        for (int k = 0; k < 5; k++) begin
            check("bp_valid", 32'(resp_valid), 1);
            check("bp_id", 32'(resp_id), 0);
            check("bp_inside", 32'(resp_inside), 1);
            check("bp_err", 32'(resp_err), 0);
            check("bp_ready", 32'(req_ready), 0);
            check("bp_done", 32'(tests_done), 7);
            tick();
        end
        req_valid  = '0;
        resp_ready = 1'b1;
        check("bp_valid6", 32'(resp_valid), 1);
        tick();
        resp_ready = 1'b0;
        check("bp_done8", 32'(tests_done), 8);
        check("bp_idle", 32'(resp_valid), 0);

        // Reset while the request sits in TEST.
        req_valid = 2'b01;
        #1;
        check("rt_grant", 32'(req_ready), 1);
        tick();
        req_valid = '0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            check("rt_no_valid", 32'(resp_valid), 0);
            check("rt_done", 32'(tests_done), 0);
            tick();
        end
        do_req(0, 150, 150, 0, 0, 1);
        load_square();
        do_req(0, 150, 150, 0, 1, 0);
        check("rt_done2", 32'(tests_done), 2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
